// File: rtl/mp3_pc_button_pkg.sv
// Shared FSM encoding and PIO register map for the button-PIO Avalon-MM master.
// Constants only; no logic, no latency, no flow control.
package mp3_pc_button_pkg;

   localparam int         PIO_W            = 4;
   localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
   localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_MASK_OFF,
      ST_WAIT,
      ST_RD_ADDR,
      ST_RD_CAP,
      ST_EVAL
   } state_t;

endpackage

// File: rtl/mp3_pc_button_timer.sv
// Load/count-down debounce timer; done marks the last cycle of a DEBOUNCE_CYCLES window.
// Load takes effect next cycle; no backpressure, counter saturates at zero.
module mp3_pc_button_timer #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic load,
   output logic done
);

   localparam int TW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [TW-1:0] count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (load) begin
         count <= TW'(DEBOUNCE_CYCLES);
      end else if (count != '0) begin
         count <= count - TW'(1);
      end
   end

   // Flagging at 1 lets the owner leave after exactly DEBOUNCE_CYCLES cycles.
   assign done = (count == TW'(1));

endmodule

// File: rtl/mp3_pc_button_master.sv
// Avalon-MM master servicing the button PIO: irq -> mask off -> debounce -> read -> event -> poll -> re-arm.
// Press-to-event DEBOUNCE_CYCLES+5 cycles; fixed-latency responder, no waitrequest/backpressure.
module mp3_pc_button_master
   import mp3_pc_button_pkg::*;
#(
   parameter int               DEBOUNCE_CYCLES = 500000,
   parameter logic [PIO_W-1:0] ENABLE_MASK     = 4'hF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             irq,
   output logic [1:0]       avm_address,
   output logic             avm_chipselect,
   output logic             avm_write_n,
   output logic [31:0]      avm_writedata,
   input  logic [31:0]      avm_readdata,
   output logic             btn_event_valid,
   output logic [PIO_W-1:0] btn_event_code,
   output logic [PIO_W-1:0] btn_state
);

   state_t           state, state_nxt;
   logic [PIO_W-1:0] sample;
   logic [PIO_W-1:0] new_press;
   logic [PIO_W-1:0] wr_mask;
   logic             wr_req, rd_req;
   logic             tmr_load, tmr_done;
   logic             unused_rd;

   assign unused_rd = ^avm_readdata[31:PIO_W];
   assign new_press = sample & ~btn_state;

   mp3_pc_button_timer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_timer (
      .clk    (clk),
      .reset_n(reset_n),
      .load   (tmr_load),
      .done   (tmr_done)
   );

   // Bus strobes are registered from the transition, so each access lands in the state it names.
   always_comb begin
      state_nxt = state;
      wr_req    = 1'b0;
      rd_req    = 1'b0;
      wr_mask   = '0;
      tmr_load  = 1'b0;
      unique case (state)
         ST_INIT: begin
            // Out of reset the write has not been issued yet, so INIT holds one extra cycle.
            if (avm_chipselect && !avm_write_n) begin
               state_nxt = ST_IDLE;
            end else begin
               wr_req  = 1'b1;
               wr_mask = ENABLE_MASK;
            end
         end
         ST_IDLE: begin
            if (irq) begin
               state_nxt = ST_MASK_OFF;
               wr_req    = 1'b1;
            end
         end
         ST_MASK_OFF: begin
            tmr_load  = 1'b1;
            state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (tmr_done) begin
               state_nxt = ST_RD_ADDR;
               rd_req    = 1'b1;
            end
         end
         ST_RD_ADDR: state_nxt = ST_RD_CAP;
         ST_RD_CAP:  state_nxt = ST_EVAL;
         ST_EVAL: begin
            if (sample != '0) begin
               tmr_load  = 1'b1;
               state_nxt = ST_WAIT;
            end else begin
               state_nxt = ST_INIT;
               wr_req    = 1'b1;
               wr_mask   = ENABLE_MASK;
            end
         end
         default: state_nxt = ST_INIT;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= ST_INIT;
         avm_address     <= PIO_ADDR_DATA;
         avm_chipselect  <= 1'b0;
         avm_write_n     <= 1'b1;
         avm_writedata   <= '0;
         btn_event_valid <= 1'b0;
         btn_event_code  <= '0;
         btn_state       <= '0;
         sample          <= '0;
      end else begin
         state           <= state_nxt;
         avm_address     <= wr_req ? PIO_ADDR_IRQMASK : PIO_ADDR_DATA;
         avm_chipselect  <= wr_req | rd_req;
         avm_write_n     <= ~wr_req;
         avm_writedata   <= {{(32-PIO_W){1'b0}}, wr_mask};
         btn_event_valid <= 1'b0;
         if (state == ST_RD_CAP) begin
            sample <= avm_readdata[PIO_W-1:0] & ENABLE_MASK;
         end
         if (state == ST_EVAL) begin
            btn_state <= sample;
            if (new_press != '0) begin
               btn_event_valid <= 1'b1;
               btn_event_code  <= new_press;
            end
         end
      end
   end

endmodule
